// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared types and constants for the pwm fade sequencer
package pwm_fade_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } fade_state_e;

    localparam int MAX_COUNTER_WIDTH = 32;

    // All-ones compare for a given width keeps the attached pwm output low.
    function automatic logic [MAX_COUNTER_WIDTH-1:0] idle_cmp(input int width);
        if (width >= MAX_COUNTER_WIDTH) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - count-enable tick generator, one tick every prescale+1 clocks
module pwm_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] prescale,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // >= rather than == so a live shrink of prescale cannot overrun the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= prescale) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - fade sequencer driving a pwm compare value and count-enable tick
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int COUNTER_WIDTH    = 10,
    parameter int PRESCALE_WIDTH   = 16,
    parameter int PERIOD_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic [PRESCALE_WIDTH-1:0]   prescale_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        continuous_i,
    input  logic [COUNTER_WIDTH-1:0]    cmp_min_i,
    input  logic [COUNTER_WIDTH-1:0]    cmp_max_i,
    input  logic [COUNTER_WIDTH-1:0]    step_i,
    input  logic [PERIOD_CNT_WIDTH-1:0] step_periods_i,
    input  logic [PERIOD_CNT_WIDTH-1:0] hold_periods_i,
    input  logic                        period_start_i,
    output logic                        pwm_set_o,
    output logic [COUNTER_WIDTH-1:0]    cmp_value_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        cfg_err_o
);

    localparam logic [COUNTER_WIDTH-1:0] CMP_IDLE = COUNTER_WIDTH'(idle_cmp(COUNTER_WIDTH));

    fade_state_e                 state;
    logic [COUNTER_WIDTH-1:0]    cmp;
    logic [PERIOD_CNT_WIDTH-1:0] per_cnt;

    logic [COUNTER_WIDTH-1:0]    min_q;
    logic [COUNTER_WIDTH-1:0]    max_q;
    logic [COUNTER_WIDTH-1:0]    step_q;
    logic [PERIOD_CNT_WIDTH-1:0] step_per_q;
    logic [PERIOD_CNT_WIDTH-1:0] hold_per_q;
    logic                        cont_q;

    logic [COUNTER_WIDTH:0]      sum_up;
    logic [COUNTER_WIDTH:0]      floor_dn;
    logic                        step_evt;
    logic                        hold_evt;

    pwm_prescaler #(
        .WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable_i),
        .prescale(prescale_i),
        .tick    (pwm_set_o)
    );

    // One extra bit so ramp arithmetic saturates at the bounds instead of wrapping.
    assign sum_up   = {1'b0, cmp} + {1'b0, step_q};
    assign floor_dn = {1'b0, min_q} + {1'b0, step_q};
    assign step_evt = period_start_i && (per_cnt == step_per_q);
    assign hold_evt = period_start_i && (per_cnt == hold_per_q);

    assign cmp_value_o = cmp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmp        <= CMP_IDLE;
            per_cnt    <= '0;
            min_q      <= '0;
            max_q      <= '0;
            step_q     <= '0;
            step_per_q <= '0;
            hold_per_q <= '0;
            cont_q     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            if (state == IDLE) begin
                if (start_i && enable_i && !stop_i) begin
                    if (cmp_min_i > cmp_max_i) begin
                        cfg_err_o <= 1'b1;
                    end else begin
                        min_q      <= cmp_min_i;
                        max_q      <= cmp_max_i;
                        step_q     <= (step_i == '0) ? COUNTER_WIDTH'(1) : step_i;
                        step_per_q <= step_periods_i;
                        hold_per_q <= hold_periods_i;
                        cont_q     <= continuous_i;
                        cmp        <= cmp_min_i;
                        per_cnt    <= '0;
                        state      <= RAMP_UP;
                        busy_o     <= 1'b1;
                    end
                end
            end else if (stop_i || !enable_i) begin
                // Abort wins over any step or hold event landing in the same cycle.
                state   <= IDLE;
                cmp     <= CMP_IDLE;
                per_cnt <= '0;
                busy_o  <= 1'b0;
            end else if (period_start_i) begin
                per_cnt <= per_cnt + 1'b1;
                case (state)
                    RAMP_UP: begin
                        if (step_evt) begin
                            per_cnt <= '0;
                            if (sum_up >= {1'b0, max_q}) begin
                                cmp   <= max_q;
                                state <= HOLD_HIGH;
                            end else begin
                                cmp <= sum_up[COUNTER_WIDTH-1:0];
                            end
                        end
                    end
                    HOLD_HIGH: begin
                        if (hold_evt) begin
                            per_cnt <= '0;
                            state   <= RAMP_DOWN;
                        end
                    end
                    RAMP_DOWN: begin
                        if (step_evt) begin
                            per_cnt <= '0;
                            if ({1'b0, cmp} < floor_dn) begin
                                cmp   <= min_q;
                                state <= HOLD_LOW;
                            end else begin
                                cmp <= cmp - step_q;
                            end
                        end
                    end
                    HOLD_LOW: begin
                        if (hold_evt) begin
                            per_cnt <= '0;
                            if (cont_q) begin
                                state <= RAMP_UP;
                            end else begin
                                state  <= IDLE;
                                cmp    <= CMP_IDLE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cmp     <= CMP_IDLE;
                        per_cnt <= '0;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [15:0] prescale_i;
    logic        start_i;
    logic        stop_i;
    logic        continuous_i;
    logic [9:0]  cmp_min_i;
    logic [9:0]  cmp_max_i;
    logic [9:0]  step_i;
    logic [7:0]  step_periods_i;
    logic [7:0]  hold_periods_i;
    logic        period_start_i;
    logic        pwm_set_o;
    logic [9:0]  cmp_value_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;

    int n_cmp = 0;
    int n_err = 0;
    int trace[$];

    always #5 clk = ~clk;

    pwm_fade_ctrl #(
        .COUNTER_WIDTH   (10),
        .PRESCALE_WIDTH  (16),
        .PERIOD_CNT_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .prescale_i    (prescale_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .continuous_i  (continuous_i),
        .cmp_min_i     (cmp_min_i),
        .cmp_max_i     (cmp_max_i),
        .step_i        (step_i),
        .step_periods_i(step_periods_i),
        .hold_periods_i(hold_periods_i),
        .period_start_i(period_start_i),
        .pwm_set_o     (pwm_set_o),
        .cmp_value_o   (cmp_value_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cfg_err_o     (cfg_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected compare value after each period event of one fade cycle.
    task automatic build_trace(input int mn, input int mx, input int st, input int sp,
                               input int hp, input bit cont);
        int cur;
        int s;
        trace.delete();
        s   = (st == 0) ? 1 : st;
        cur = mn;
        while (1) begin
            repeat (sp) trace.push_back(cur);
            if (cur + s >= mx) begin
                cur = mx;
                trace.push_back(cur);
                break;
            end
            cur = cur + s;
            trace.push_back(cur);
        end
        repeat (hp + 1) trace.push_back(cur);
        while (1) begin
            repeat (sp) trace.push_back(cur);
            if (cur < mn + s) begin
                cur = mn;
                trace.push_back(cur);
                break;
            end
            cur = cur - s;
            trace.push_back(cur);
        end
        repeat (hp) trace.push_back(cur);
        trace.push_back(cont ? cur : 1023);
    endtask

    task automatic pulse_event();
        period_start_i = 1'b1;
        @(negedge clk);
        period_start_i = 1'b0;
    endtask

    task automatic apply_start(input int mn, input int mx, input int st, input int sp,
                               input int hp, input bit cont);
        cmp_min_i      = 10'(mn);
        cmp_max_i      = 10'(mx);
        step_i         = 10'(st);
        step_periods_i = 8'(sp);
        hold_periods_i = 8'(hp);
        continuous_i   = cont;
        start_i        = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_fade(input string tag, input int mn, input int mx, input int st,
                            input int sp, input int hp, input bit cont, input int cycles);
        bit last;
        build_trace(mn, mx, st, sp, hp, cont);
        period_start_i = 1'($urandom_range(0, 1));
        apply_start(mn, mx, st, sp, hp, cont);
        period_start_i = 1'b0;
        cmp_min_i      = 10'($urandom_range(0, 1023));
        cmp_max_i      = 10'($urandom_range(0, 1023));
        step_i         = 10'($urandom_range(0, 1023));
        step_periods_i = 8'($urandom_range(0, 255));
        hold_periods_i = 8'($urandom_range(0, 255));
        continuous_i   = ~cont;
        chk({tag, " start_cmp"}, 32'(cmp_value_o), mn);
        chk({tag, " start_busy"}, 32'(busy_o), 1);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < trace.size(); i++) begin
                pulse_event();
                last = (c == cycles - 1) && (i == trace.size() - 1) && !cont;
                chk($sformatf("%s c%0d ev%0d cmp", tag, c, i), 32'(cmp_value_o), trace[i]);
                chk($sformatf("%s c%0d ev%0d busy", tag, c, i), 32'(busy_o), last ? 0 : 1);
                chk($sformatf("%s c%0d ev%0d done", tag, c, i), 32'(done_o), last ? 1 : 0);
                @(negedge clk);
            end
        end
        if (!cont) chk({tag, " done_cleared"}, 32'(done_o), 0);
    endtask

    initial begin
        int p;
        int mn;
        int mx;
        int st;
        rst_n          = 1'b0;
        enable_i       = 1'b0;
        prescale_i     = '0;
        start_i        = 1'b0;
        stop_i         = 1'b0;
        continuous_i   = 1'b0;
        cmp_min_i      = '0;
        cmp_max_i      = '0;
        step_i         = '0;
        step_periods_i = '0;
        hold_periods_i = '0;
        period_start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst cmp", 32'(cmp_value_o), 1023);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst cfg_err", 32'(cfg_err_o), 0);
        chk("rst pwm_set", 32'(pwm_set_o), 0);
        rst_n = 1'b1;

        prescale_i = 16'd3;
        enable_i   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("presc3 k%0d", k), 32'(pwm_set_o), (k % 4 == 0) ? 1 : 0);
        end
        prescale_i = 16'd0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("presc0 k%0d", k), 32'(pwm_set_o), 1);
        end
        enable_i = 1'b0;
        @(negedge clk);
        chk("presc disable", 32'(pwm_set_o), 0);

        p          = $urandom_range(1, 6);
        prescale_i = 16'(p);
        enable_i   = 1'b1;
        for (int k = 1; k <= 3 * (p + 1); k++) begin
            @(negedge clk);
            chk($sformatf("presc%0d k%0d", p, k), 32'(pwm_set_o), (k % (p + 1) == 0) ? 1 : 0);
        end
        prescale_i = 16'd2;

        run_fade("oneshot", 100, 400, 100, 0, 1, 1'b0, 1);
        run_fade("saturate", 0, 1023, 1000, 0, 0, 1'b0, 1);
        run_fade("step0_eq", 5, 5, 0, 0, 0, 1'b0, 1);
        for (int r = 0; r < 6; r++) begin
            mn = $urandom_range(0, 900);
            mx = $urandom_range(mn, 1023);
            st = $urandom_range((mx - mn) / 6, mx - mn);
            run_fade($sformatf("rand%0d", r), mn, mx, st, $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'b0, 1);
        end

        apply_start(100, 400, 100, 0, 0, 1'b0);
        repeat (5) begin
            pulse_event();
            @(negedge clk);
        end
        chk("abort pre cmp", 32'(cmp_value_o), 300);
        cmp_min_i = 10'd7;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start ignored cmp", 32'(cmp_value_o), 300);
        chk("start ignored busy", 32'(busy_o), 1);
        stop_i         = 1'b1;
        start_i        = 1'b1;
        period_start_i = 1'b1;
        @(negedge clk);
        stop_i         = 1'b0;
        start_i        = 1'b0;
        period_start_i = 1'b0;
        chk("abort cmp", 32'(cmp_value_o), 1023);
        chk("abort busy", 32'(busy_o), 0);
        chk("abort done", 32'(done_o), 0);

        apply_start(10, 5, 1, 0, 0, 1'b0);
        chk("cfg_err pulse", 32'(cfg_err_o), 1);
        chk("cfg_err busy", 32'(busy_o), 0);
        chk("cfg_err cmp", 32'(cmp_value_o), 1023);
        @(negedge clk);
        chk("cfg_err clear", 32'(cfg_err_o), 0);

        apply_start(100, 400, 100, 0, 0, 1'b0);
        pulse_event();
        chk("en_drop pre cmp", 32'(cmp_value_o), 200);
        enable_i = 1'b0;
        @(negedge clk);
        chk("en_drop cmp", 32'(cmp_value_o), 1023);
        chk("en_drop busy", 32'(busy_o), 0);
        chk("en_drop done", 32'(done_o), 0);
        enable_i = 1'b1;
        @(negedge clk);

        mn = $urandom_range(0, 500);
        mx = $urandom_range(mn, 1023);
        st = $urandom_range((mx - mn) / 5, mx - mn);
        run_fade("cont", mn, mx, st, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 3);
        chk("cont still busy", 32'(busy_o), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst cmp", 32'(cmp_value_o), 1023);
        chk("midrst busy", 32'(busy_o), 0);
        chk("midrst done", 32'(done_o), 0);
        chk("midrst cfg_err", 32'(cfg_err_o), 0);
        chk("midrst pwm_set", 32'(pwm_set_o), 0);
        rst_n = 1'b1;
        pulse_event();
        chk("postrst idle busy", 32'(busy_o), 0);
        chk("postrst idle cmp", 32'(cmp_value_o), 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
